// File: rtl/countdown_timer_if.sv
// Control/status bundle between the game logic and the detonation countdown timer.
interface countdown_timer_if #(
    parameter int WIDTH = 16
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             pause;
    logic             auto_reload;
    logic             penalty_valid;
    logic [WIDTH-1:0] penalty;
    logic [WIDTH-1:0] count;
    logic             running;
    logic             paused;
    logic             done;
    logic             expired;

    modport master (
        output load, load_val, start, pause, auto_reload, penalty_valid, penalty,
        input  count, running, paused, done, expired
    );

    modport slave (
        input  load, load_val, start, pause, auto_reload, penalty_valid, penalty,
        output count, running, paused, done, expired
    );
endinterface

// File: rtl/countdown_timer.sv
// Detonation clock: prescaled countdown with pause/resume, one-shot or auto-reload,
// and saturating time penalties. All outputs come straight from registers.
//
// state  | meaning
// IDLE   | loaded or reset, waiting for start
// RUN    | prescaler advancing, count decrements on each tick
// PAUSED | count and prescaler frozen, waiting for start
// DONE   | expired (one-shot or penalty), count held at 0 until load
module countdown_timer #(
    parameter int WIDTH    = 16,
    parameter int PRESCALE = 1
) (
    input logic              clk,
    input logic              rst,
    countdown_timer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

    localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [15:0]      presc_q, presc_d;
    logic             expired_q, expired_d;
    logic             tick;
    logic [WIDTH:0]   dec;

    // A pause request freezes the prescaler on the same edge, so no tick is taken.
    assign tick = (state_q == RUN) && !bus.pause && (presc_q == PS_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            presc_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            presc_q   <= presc_d;
            expired_q <= expired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        presc_d   = presc_q;
        expired_d = 1'b0;
        dec       = {1'b0, bus.penalty} + {{WIDTH{1'b0}}, tick};

        if (bus.load) begin
            count_d  = bus.load_val;
            reload_d = bus.load_val;
            presc_d  = '0;
            state_d  = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (bus.start && count_q != '0) state_d = RUN;
                RUN:     if (bus.pause) state_d = PAUSED;
                         else presc_d = tick ? 16'd0 : presc_q + 16'd1;
                PAUSED:  if (bus.start) state_d = RUN;
                default: ;
            endcase

            // Penalty folds in a coincident tick and always ends the game on saturation.
            if (bus.penalty_valid && (state_q == RUN || state_q == PAUSED)) begin
                if (dec < {1'b0, count_q}) begin
                    count_d = count_q - dec[WIDTH-1:0];
                end else begin
                    count_d   = '0;
                    state_d   = DONE;
                    presc_d   = '0;
                    expired_d = 1'b1;
                end
            end else if (tick) begin
                if (count_q > WIDTH'(1)) begin
                    count_d = count_q - WIDTH'(1);
                end else begin
                    expired_d = 1'b1;
                    if (bus.auto_reload) begin
                        count_d = reload_q;
                    end else begin
                        count_d = '0;
                        state_d = DONE;
                        presc_d = '0;
                    end
                end
            end
        end
    end

    assign bus.count   = count_q;
    assign bus.running = (state_q == RUN);
    assign bus.paused  = (state_q == PAUSED);
    assign bus.done    = (state_q == DONE);
    assign bus.expired = expired_q;
endmodule

// File: tb/tb_countdown_timer.sv
// Bench: three timers (PRESCALE 1, 3, 4) share one stimulus stream and are each
// compared every cycle against a behavioural model, plus a vector table and corner sequences.
module tb_countdown_timer;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;
    localparam int PS [3] = '{1, 3, 4};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v, load_v, start_v, pause_v, ar_v, pv_v;
    logic [15:0] val_v, pen_v;

    countdown_timer_if #(.WIDTH(16)) bus1 ();
    countdown_timer_if #(.WIDTH(16)) bus3 ();
    countdown_timer_if #(.WIDTH(16)) bus4 ();

    assign bus1.load = load_v;          assign bus3.load = load_v;          assign bus4.load = load_v;
    assign bus1.load_val = val_v;       assign bus3.load_val = val_v;       assign bus4.load_val = val_v;
    assign bus1.start = start_v;        assign bus3.start = start_v;        assign bus4.start = start_v;
    assign bus1.pause = pause_v;        assign bus3.pause = pause_v;        assign bus4.pause = pause_v;
    assign bus1.auto_reload = ar_v;     assign bus3.auto_reload = ar_v;     assign bus4.auto_reload = ar_v;
    assign bus1.penalty_valid = pv_v;   assign bus3.penalty_valid = pv_v;   assign bus4.penalty_valid = pv_v;
    assign bus1.penalty = pen_v;        assign bus3.penalty = pen_v;        assign bus4.penalty = pen_v;

    countdown_timer #(.WIDTH(16), .PRESCALE(1)) u1 (.clk(clk), .rst(rst_v), .bus(bus1));
    countdown_timer #(.WIDTH(16), .PRESCALE(3)) u3 (.clk(clk), .rst(rst_v), .bus(bus3));
    countdown_timer #(.WIDTH(16), .PRESCALE(4)) u4 (.clk(clk), .rst(rst_v), .bus(bus4));

    // Observed outputs packed as {count, running, paused, done, expired}.
    logic [19:0] o_vec [3];
    assign o_vec[0] = {bus1.count, bus1.running, bus1.paused, bus1.done, bus1.expired};
    assign o_vec[1] = {bus3.count, bus3.running, bus3.paused, bus3.done, bus3.expired};
    assign o_vec[2] = {bus4.count, bus4.running, bus4.paused, bus4.done, bus4.expired};

    typedef struct {
        int cnt;
        int rld;
        int phase;
        int st;
        bit exp;
    } mdl_t;
    mdl_t mdl [3];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic mdl_t mstep(input mdl_t m, input int ps);
        mdl_t n;
        bit   counting, tick;
        int   d;
        n = m;
        n.exp = 0;
        if (!rst_v) begin
            n.cnt = 0; n.rld = 0; n.phase = 0; n.st = S_IDLE;
            return n;
        end
        if (load_v) begin
            n.cnt = int'(val_v); n.rld = int'(val_v); n.phase = 0; n.st = S_IDLE;
            return n;
        end
        counting = (m.st == S_RUN) && !pause_v;
        tick = counting && ((m.phase + 1) % ps == 0);
        if (counting) n.phase = (m.phase + 1) % ps;
        if (m.st == S_IDLE && start_v && m.cnt != 0) n.st = S_RUN;
        if (m.st == S_RUN && pause_v) n.st = S_PAUSE;
        if (m.st == S_PAUSE && start_v) n.st = S_RUN;
        if (pv_v && (m.st == S_RUN || m.st == S_PAUSE)) begin
            d = int'(pen_v) + (tick ? 1 : 0);
            if (d >= m.cnt) begin
                n.cnt = 0; n.st = S_DONE; n.exp = 1;
            end else begin
                n.cnt = m.cnt - d;
            end
        end else if (tick) begin
            if (m.cnt == 1) begin
                n.exp = 1;
                if (ar_v) n.cnt = m.rld;
                else begin n.cnt = 0; n.st = S_DONE; end
            end else begin
                n.cnt = m.cnt - 1;
            end
        end
        return n;
    endfunction

    function automatic logic [19:0] mpack(input mdl_t m);
        return {16'(m.cnt), m.st == S_RUN, m.st == S_PAUSE, m.st == S_DONE, m.exp};
    endfunction

    task automatic cycle();
        @(posedge clk);
        for (int i = 0; i < 3; i++) mdl[i] = mstep(mdl[i], PS[i]);
        #1;
        for (int i = 0; i < 3; i++)
            chk($sformatf("model_ps%0d", PS[i]), 32'(o_vec[i]), 32'(mpack(mdl[i])));
    endtask

    task automatic quiet();
        rst_v = 1; load_v = 0; val_v = 0; start_v = 0; pause_v = 0;
        ar_v = 0; pv_v = 0; pen_v = 0;
    endtask

    typedef struct {
        bit r, ld; int val; bit st, pa, pv; int pen; bit ar;
        int e_cnt; bit e_run, e_pau, e_done, e_exp;
    } vec_t;
    vec_t tbl [20];

    int n;

    initial begin
        for (int i = 0; i < 3; i++) begin
            mdl[i].cnt = 0; mdl[i].rld = 0; mdl[i].phase = 0; mdl[i].st = S_IDLE; mdl[i].exp = 0;
        end
        quiet();

        //          r ld val st pa pv pen ar | cnt run pau done exp
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 0,  0,   0, 0, 0, 0, 0};
        tbl[1]  = '{1, 1, 5, 1, 0, 0, 0,  0,   5, 0, 0, 0, 0};
        tbl[2]  = '{1, 0, 0, 0, 0, 1, 2,  0,   5, 0, 0, 0, 0};
        tbl[3]  = '{1, 0, 0, 1, 0, 0, 0,  0,   5, 1, 0, 0, 0};
        tbl[4]  = '{1, 0, 0, 0, 0, 0, 0,  0,   4, 1, 0, 0, 0};
        tbl[5]  = '{1, 0, 0, 1, 1, 0, 0,  0,   4, 0, 1, 0, 0};
        tbl[6]  = '{1, 0, 0, 0, 0, 0, 0,  0,   4, 0, 1, 0, 0};
        tbl[7]  = '{1, 0, 0, 1, 1, 0, 0,  0,   4, 1, 0, 0, 0};
        tbl[8]  = '{1, 0, 0, 0, 0, 0, 0,  0,   3, 1, 0, 0, 0};
        tbl[9]  = '{1, 1, 0, 0, 0, 0, 0,  0,   0, 0, 0, 0, 0};
        tbl[10] = '{1, 0, 0, 1, 0, 0, 0,  0,   0, 0, 0, 0, 0};
        tbl[11] = '{1, 1, 2, 1, 0, 0, 0,  1,   2, 0, 0, 0, 0};
        tbl[12] = '{1, 0, 0, 1, 0, 0, 0,  1,   2, 1, 0, 0, 0};
        tbl[13] = '{1, 0, 0, 0, 0, 0, 0,  1,   1, 1, 0, 0, 0};
        tbl[14] = '{1, 0, 0, 0, 0, 0, 0,  1,   2, 1, 0, 0, 1};
        tbl[15] = '{1, 0, 0, 0, 0, 0, 0,  1,   1, 1, 0, 0, 0};
        tbl[16] = '{1, 0, 0, 0, 0, 0, 0,  1,   2, 1, 0, 0, 1};
        tbl[17] = '{1, 0, 0, 0, 0, 1, 20, 1,   0, 0, 0, 1, 1};
        tbl[18] = '{1, 0, 0, 0, 0, 0, 0,  1,   0, 0, 0, 1, 0};
        tbl[19] = '{1, 0, 0, 1, 0, 0, 0,  0,   0, 0, 0, 1, 0};

        // Vector table against the PRESCALE=1 instance.
        for (int i = 0; i < 20; i++) begin
            rst_v = tbl[i].r; load_v = tbl[i].ld; val_v = 16'(tbl[i].val);
            start_v = tbl[i].st; pause_v = tbl[i].pa; pv_v = tbl[i].pv;
            pen_v = 16'(tbl[i].pen); ar_v = tbl[i].ar;
            cycle();
            chk($sformatf("vec%0d", i), 32'(o_vec[0]),
                32'({16'(tbl[i].e_cnt), tbl[i].e_run, tbl[i].e_pau, tbl[i].e_done, tbl[i].e_exp}));
        end

        // PRESCALE=4 one-shot: ticks at edges 4, 8, 12 after start.
        quiet(); load_v = 1; val_v = 3; cycle();
        quiet(); start_v = 1; cycle();
        chk("ps4_running", 32'(bus4.running), 32'd1);
        quiet();
        for (int k = 1; k <= 12; k++) begin
            cycle();
            chk($sformatf("ps4_count_k%0d", k), 32'(bus4.count), 32'(3 - k / 4));
            chk($sformatf("ps4_expired_k%0d", k), 32'(bus4.expired), 32'(k == 12));
        end
        chk("ps4_done", 32'({bus4.done, bus4.running}), 32'b10);

        // PRESCALE=3, load 5, prescaler frozen for 10 edges mid-period.
        quiet(); load_v = 1; val_v = 5; cycle();
        quiet(); start_v = 1; cycle();
        quiet();
        for (int k = 0; k < 4; k++) cycle();
        pause_v = 1; cycle();
        chk("ps3_paused_entry", 32'(bus3.paused), 32'd1);
        quiet();
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("ps3_paused_hold", 32'(bus3.paused), 32'd1);
        end
        start_v = 1; cycle();
        quiet();
        n = 14;
        while (n < 60) begin
            cycle();
            n++;
            if (bus3.expired) break;
        end
        chk("ps3_expiry_edge", 32'(n), 32'd25);

        // Penalty coinciding with a tick, then a saturating penalty under auto-reload.
        quiet(); load_v = 1; val_v = 10; cycle();
        quiet(); start_v = 1; cycle();
        quiet(); pv_v = 1; pen_v = 3; cycle();
        chk("pen_tick_count", 32'(bus1.count), 32'd6);
        quiet(); pv_v = 1; pen_v = 20; ar_v = 1; cycle();
        chk("pen_sat", 32'(o_vec[0]), 32'({16'd0, 1'b0, 1'b0, 1'b1, 1'b1}));

        // Reset mid-run at count 7, then start must be ignored.
        quiet(); load_v = 1; val_v = 9; cycle();
        quiet(); start_v = 1; cycle();
        quiet(); cycle(); cycle();
        chk("rst_pre_count", 32'(bus1.count), 32'd7);
        rst_v = 0; cycle();
        chk("rst_clear", 32'(o_vec[0]), 32'd0);
        quiet(); start_v = 1; cycle();
        chk("rst_start_ignored", 32'(o_vec[0]), 32'd0);

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            rst_v   = ($urandom_range(0, 199) != 0);
            load_v  = ($urandom_range(0, 39) == 0);
            val_v   = 16'($urandom_range(0, 20));
            start_v = ($urandom_range(0, 4) == 0);
            pause_v = ($urandom_range(0, 9) == 0);
            ar_v    = $urandom_range(0, 1) == 1;
            pv_v    = ($urandom_range(0, 14) == 0);
            pen_v   = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 65535))
                                                  : 16'($urandom_range(0, 6));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
